// File: rtl/systolic_ctrl_2x2.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl_2x2
// Purpose  : Sequencer for a 2x2 double-buffered weight-stationary systolic
//            array: weight-set loading, skewed A feed, C capture and return.
// Revision : 1.0  initial release
// ============================================================================
module systolic_ctrl_2x2 #(
    parameter int DW = 4,
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_b00,
    input  logic [DW-1:0] w_b01,
    input  logic [DW-1:0] w_b10,
    input  logic [DW-1:0] w_b11,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] a_a00,
    input  logic [DW-1:0] a_a01,
    input  logic [DW-1:0] a_a10,
    input  logic [DW-1:0] a_a11,

    output logic          c_valid,
    input  logic          c_ready,
    output logic [CW-1:0] c_c00,
    output logic [CW-1:0] c_c01,
    output logic [CW-1:0] c_c10,
    output logic [CW-1:0] c_c11,

    output logic [DW-1:0] arr_a_row0,
    output logic [DW-1:0] arr_a_row1,
    output logic [DW-1:0] arr_b00,
    output logic [DW-1:0] arr_b01,
    output logic [DW-1:0] arr_b10,
    output logic [DW-1:0] arr_b11,
    output logic          arr_load_row0,
    output logic          arr_load_row1,
    output logic          arr_sel_w_load,
    output logic          arr_sel_w_active,
    output logic          arr_clear_psum,
    output logic          arr_compute_en,
    input  logic [CW-1:0] arr_c10,
    input  logic [CW-1:0] arr_c11
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] C_T_LAST = 3'd4;

    state_t        r_state;
    logic [2:0]    r_t;
    logic [1:0]    r_full;
    logic          r_wr_ptr;
    logic          r_rd_ptr;

    logic [DW-1:0] r_a00;
    logic [DW-1:0] r_a01;
    logic [DW-1:0] r_a10;
    logic [DW-1:0] r_a11;

    logic          r_clear_psum;
    logic          r_compute_en;
    logic          r_c_valid;
    logic [DW-1:0] r_row0;
    logic [DW-1:0] r_row1;
    logic [CW-1:0] r_c00;
    logic [CW-1:0] r_c01;
    logic [CW-1:0] r_c10;
    logic [CW-1:0] r_c11;

    logic          w_wt_fire;
    logic          w_job_fire;
    logic          w_buf_free;
    logic [1:0]    w_full_next;

    // Readies come only from registered state, so nothing bypasses a cycle.
    assign w_ready    = ~r_full[r_wr_ptr];
    assign a_ready    = (r_state == S_IDLE) & r_full[r_rd_ptr];
    assign w_wt_fire  = w_valid & w_ready;
    assign w_job_fire = a_valid & a_ready;
    assign w_buf_free = (r_state == S_RUN) && (r_t == C_T_LAST);

    assign arr_load_row0    = w_wt_fire;
    assign arr_load_row1    = w_wt_fire;
    assign arr_b00          = w_wt_fire ? w_b00 : '0;
    assign arr_b01          = w_wt_fire ? w_b01 : '0;
    assign arr_b10          = w_wt_fire ? w_b10 : '0;
    assign arr_b11          = w_wt_fire ? w_b11 : '0;
    assign arr_sel_w_load   = r_wr_ptr;
    assign arr_sel_w_active = r_rd_ptr;

    assign arr_clear_psum = r_clear_psum;
    assign arr_compute_en = r_compute_en;
    assign arr_a_row0     = r_row0;
    assign arr_a_row1     = r_row1;
    assign c_valid        = r_c_valid;
    assign c_c00          = r_c00;
    assign c_c01          = r_c01;
    assign c_c10          = r_c10;
    assign c_c11          = r_c11;

    // A load never targets the buffer being freed: that one is still full.
    always_comb begin
        w_full_next = r_full;
        if (w_buf_free) begin
            w_full_next[r_rd_ptr] = 1'b0;
        end
        if (w_wt_fire) begin
            w_full_next[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_ptr <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_wt_fire) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
        end
    end

    // Outputs for the next step are set on the transition into that step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_t          <= 3'd0;
            r_rd_ptr     <= 1'b0;
            r_a00        <= '0;
            r_a01        <= '0;
            r_a10        <= '0;
            r_a11        <= '0;
            r_clear_psum <= 1'b0;
            r_compute_en <= 1'b0;
            r_c_valid    <= 1'b0;
            r_row0       <= '0;
            r_row1       <= '0;
            r_c00        <= '0;
            r_c01        <= '0;
            r_c10        <= '0;
            r_c11        <= '0;
        end else begin
            r_clear_psum <= 1'b0;
            r_compute_en <= 1'b0;
            r_row0       <= '0;
            r_row1       <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_job_fire) begin
                        r_a00        <= a_a00;
                        r_a01        <= a_a01;
                        r_a10        <= a_a10;
                        r_a11        <= a_a11;
                        r_clear_psum <= 1'b1;
                        r_state      <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_t          <= 3'd0;
                    r_compute_en <= 1'b1;
                    r_row0       <= r_a00;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    case (r_t)
                        3'd0: begin
                            r_t          <= 3'd1;
                            r_compute_en <= 1'b1;
                            r_row0       <= r_a10;
                            r_row1       <= r_a01;
                        end
                        3'd1: begin
                            r_t          <= 3'd2;
                            r_compute_en <= 1'b1;
                            r_row1       <= r_a11;
                        end
                        3'd2: begin
                            r_t          <= 3'd3;
                            r_compute_en <= 1'b1;
                            r_c00        <= arr_c10;
                        end
                        3'd3: begin
                            r_t   <= C_T_LAST;
                            r_c10 <= arr_c10;
                            r_c01 <= arr_c11;
                        end
                        default: begin
                            r_c11     <= arr_c11;
                            r_rd_ptr  <= ~r_rd_ptr;
                            r_c_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    if (c_ready) begin
                        r_c_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl_2x2
// Purpose  : Scoreboard bench for systolic_ctrl_2x2 with an array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_ctrl_2x2;

    localparam int DW = 4;
    localparam int CW = 9;

    typedef logic [4*DW-1:0] wset_t;
    typedef struct packed {
        logic [CW-1:0] c00;
        logic [CW-1:0] c01;
        logic [CW-1:0] c10;
        logic [CW-1:0] c11;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_b00 = '0, w_b01 = '0, w_b10 = '0, w_b11 = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] a_a00 = '0, a_a01 = '0, a_a10 = '0, a_a11 = '0;
    logic          c_valid;
    logic          c_ready;
    logic [CW-1:0] c_c00, c_c01, c_c10, c_c11;
    logic [DW-1:0] arr_a_row0, arr_a_row1;
    logic [DW-1:0] arr_b00, arr_b01, arr_b10, arr_b11;
    logic          arr_load_row0, arr_load_row1;
    logic          arr_sel_w_load, arr_sel_w_active;
    logic          arr_clear_psum, arr_compute_en;
    logic [CW-1:0] arr_c10, arr_c11;

    logic cr_dir = 1'b1;
    logic rnd_bp = 1'b0;
    logic rnd_cr = 1'b1;
    assign c_ready = rnd_bp ? rnd_cr : cr_dir;

    always #5 clk = ~clk;

    systolic_ctrl_2x2 #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_b00(w_b00), .w_b01(w_b01), .w_b10(w_b10), .w_b11(w_b11),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_a00(a_a00), .a_a01(a_a01), .a_a10(a_a10), .a_a11(a_a11),
        .c_valid(c_valid), .c_ready(c_ready),
        .c_c00(c_c00), .c_c01(c_c01), .c_c10(c_c10), .c_c11(c_c11),
        .arr_a_row0(arr_a_row0), .arr_a_row1(arr_a_row1),
        .arr_b00(arr_b00), .arr_b01(arr_b01), .arr_b10(arr_b10), .arr_b11(arr_b11),
        .arr_load_row0(arr_load_row0), .arr_load_row1(arr_load_row1),
        .arr_sel_w_load(arr_sel_w_load), .arr_sel_w_active(arr_sel_w_active),
        .arr_clear_psum(arr_clear_psum), .arr_compute_en(arr_compute_en),
        .arr_c10(arr_c10), .arr_c11(arr_c11)
    );

    // Behavioural 2x2 array: A flows right, partial sums flow down.
    logic [DW-1:0] wbuf [2][2][2];
    logic [DW-1:0] aout [2][2];
    logic [CW-1:0] psum [2][2];
    assign arr_c10 = psum[1][0];
    assign arr_c11 = psum[1][1];

    always @(posedge clk) begin
        if (arr_load_row0) begin
            wbuf[arr_sel_w_load][0][0] <= arr_b00;
            wbuf[arr_sel_w_load][0][1] <= arr_b01;
        end
        if (arr_load_row1) begin
            wbuf[arr_sel_w_load][1][0] <= arr_b10;
            wbuf[arr_sel_w_load][1][1] <= arr_b11;
        end
        aout[0][0] <= arr_a_row0;
        aout[0][1] <= aout[0][0];
        aout[1][0] <= arr_a_row1;
        aout[1][1] <= aout[1][0];
        if (arr_clear_psum) begin
            psum[0][0] <= '0; psum[0][1] <= '0; psum[1][0] <= '0; psum[1][1] <= '0;
        end else if (arr_compute_en) begin
            psum[0][0] <= CW'(int'(arr_a_row0) * int'(wbuf[arr_sel_w_active][0][0]));
            psum[0][1] <= CW'(int'(aout[0][0]) * int'(wbuf[arr_sel_w_active][0][1]));
            psum[1][0] <= CW'(int'(psum[0][0]) + int'(arr_a_row1) * int'(wbuf[arr_sel_w_active][1][0]));
            psum[1][1] <= CW'(int'(psum[0][1]) + int'(aout[1][0]) * int'(wbuf[arr_sel_w_active][1][1]));
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: actual=none required=event (cycle %0d)", name, cyc);
    endtask

    function automatic res_t matmul(input wset_t a, input wset_t b);
        int A [2][2];
        int B [2][2];
        res_t r;
        for (int i = 0; i < 4; i++) begin
            A[i/2][i%2] = int'(a[(3-i)*DW +: DW]);
            B[i/2][i%2] = int'(b[(3-i)*DW +: DW]);
        end
        r.c00 = CW'(A[0][0]*B[0][0] + A[0][1]*B[1][0]);
        r.c01 = CW'(A[0][0]*B[0][1] + A[0][1]*B[1][1]);
        r.c10 = CW'(A[1][0]*B[0][0] + A[1][1]*B[1][0]);
        r.c11 = CW'(A[1][0]*B[0][1] + A[1][1]*B[1][1]);
        return r;
    endfunction

    // Reference model state: transaction counts and the job timeline.
    wset_t         wq [$];
    res_t          sbq [$];
    bit            busy = 1'b0;
    int            acc = 0;
    int            occ = 0;
    int            nloads = 0;
    int            nfrees = 0;
    int            njobs = 0;
    logic [DW-1:0] ja00, ja01, ja10, ja11;
    int            d;
    int            er0, er1, eb;
    res_t          hr;

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0; occ = 0; nloads = 0; nfrees = 0; njobs = 0;
            wq.delete();
            sbq.delete();
        end else begin
            d = cyc - acc;
            check("clear_psum", int'(arr_clear_psum), int'(busy && d == 1));
            check("compute_en", int'(arr_compute_en), int'(busy && d >= 2 && d <= 5));
            er0 = 0;
            er1 = 0;
            if (busy && d == 2) er0 = int'(ja00);
            if (busy && d == 3) begin er0 = int'(ja10); er1 = int'(ja01); end
            if (busy && d == 4) er1 = int'(ja11);
            check("a_row0", int'(arr_a_row0), er0);
            check("a_row1", int'(arr_a_row1), er1);
            check("c_valid", int'(c_valid), int'(busy && d >= 7));
            check("w_ready", int'(w_ready), int'(occ < 2));
            check("a_ready", int'(a_ready), int'(!busy && (nloads - njobs) > 0));
            check("sel_w_load", int'(arr_sel_w_load), nloads % 2);
            check("sel_w_active", int'(arr_sel_w_active), nfrees % 2);
            eb = (w_valid && w_ready) ? int'({w_b00, w_b01, w_b10, w_b11}) : 0;
            check("load_row0", int'(arr_load_row0), int'(w_valid && w_ready));
            check("load_row1", int'(arr_load_row1), int'(w_valid && w_ready));
            check("arr_b", int'({arr_b00, arr_b01, arr_b10, arr_b11}), eb);
            if (c_valid) begin
                if (sbq.size() > 0) begin
                    hr = sbq[0];
                    check("c00", int'(c_c00), int'(hr.c00));
                    check("c01", int'(c_c01), int'(hr.c01));
                    check("c10", int'(c_c10), int'(hr.c10));
                    check("c11", int'(c_c11), int'(hr.c11));
                end else begin
                    fail("unexpected_result");
                end
            end
            if (w_valid && w_ready) begin
                wq.push_back({w_b00, w_b01, w_b10, w_b11});
                nloads++;
                occ++;
            end
            if (busy && d == 6) begin
                occ--;
                nfrees++;
            end
            if (c_valid && c_ready) begin
                if (sbq.size() > 0) void'(sbq.pop_front());
                busy = 1'b0;
            end
            if (a_valid && a_ready) begin
                busy = 1'b1;
                acc  = cyc;
                ja00 = a_a00; ja01 = a_a01; ja10 = a_a10; ja11 = a_a11;
                njobs++;
                if (wq.size() > 0) sbq.push_back(matmul({a_a00, a_a01, a_a10, a_a11}, wq.pop_front()));
                else fail("job_without_weights");
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rnd_cr = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [DW-1:0] rv();
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_w(input logic [DW-1:0] b00, b01, b10, b11);
        bit ok = 1'b0;
        w_b00 = b00; w_b01 = b01; w_b10 = b10; w_b11 = b11;
        w_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (w_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("w_handshake_timeout");
        tick(1);
        w_valid = 1'b0;
        w_b00 = '0; w_b01 = '0; w_b10 = '0; w_b11 = '0;
    endtask

    task automatic send_a(input logic [DW-1:0] x00, x01, x10, x11);
        bit ok = 1'b0;
        a_a00 = x00; a_a01 = x01; a_a10 = x10; a_a11 = x11;
        a_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("a_handshake_timeout");
        tick(1);
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && sbq.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail("drain_timeout");
        tick(1);
    endtask

    task automatic check_reset_state();
        check("rst_w_ready", int'(w_ready), 1);
        check("rst_a_ready", int'(a_ready), 0);
        check("rst_c_valid", int'(c_valid), 0);
        check("rst_c", int'({c_c00, c_c01, c_c10, c_c11}), 0);
        check("rst_rows", int'({arr_a_row0, arr_a_row1}), 0);
        check("rst_ctrl", int'({arr_clear_psum, arr_compute_en, arr_load_row0, arr_load_row1}), 0);
        check("rst_sel", int'({arr_sel_w_load, arr_sel_w_active}), 0);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        check_reset_state();

        // Job offered with no weights loaded must not start.
        a_a00 = 4'd3; a_a01 = 4'd1; a_a10 = 4'd2; a_a11 = 4'd5;
        a_valid = 1'b1;
        tick(10);
        a_valid = 1'b0;

        send_w(4'd1, 4'd2, 4'd3, 4'd4);
        send_a(4'd5, 4'd6, 4'd7, 4'd8);
        wait_drain();

        send_w(4'd15, 4'd15, 4'd15, 4'd15);
        send_a(4'd15, 4'd15, 4'd15, 4'd15);
        wait_drain();

        // Double buffer: second set loads while the first job runs.
        send_w(4'd2, 4'd0, 4'd1, 4'd3);
        send_a(4'd4, 4'd9, 4'd6, 4'd1);
        tick(2);
        send_w(4'd7, 4'd5, 4'd11, 4'd2);
        fork
            send_w(4'd13, 4'd1, 4'd0, 4'd9);
            send_a(4'd10, 4'd3, 4'd12, 4'd14);
        join
        wait_drain();
        send_a(4'd1, 4'd15, 4'd8, 4'd6);
        wait_drain();

        // Backpressure on the result port.
        cr_dir = 1'b0;
        send_w(4'd9, 4'd8, 4'd7, 4'd6);
        send_w(4'd3, 4'd12, 4'd5, 4'd10);
        send_a(4'd11, 4'd2, 4'd14, 4'd4);
        tick(17);
        cr_dir = 1'b1;
        wait_drain();
        send_a(4'd6, 4'd7, 4'd8, 4'd9);
        wait_drain();

        rnd_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            fork
                send_w(rv(), rv(), rv(), rv());
                begin
                    tick(int'($urandom_range(0, 4)));
                    send_a(rv(), rv(), rv(), rv());
                end
            join
        end
        wait_drain();
        rnd_bp = 1'b0;

        // Reset in the middle of RUN drops the job and the loaded weights.
        send_w(4'd4, 4'd4, 4'd4, 4'd4);
        send_w(4'd5, 4'd5, 4'd5, 4'd5);
        send_a(4'd2, 4'd2, 4'd2, 4'd2);
        tick(3);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_reset_state();
        send_w(4'd1, 4'd0, 4'd0, 4'd1);
        send_a(4'd9, 4'd8, 4'd7, 4'd6);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
